// File: rtl/btn_bounce_if.sv
// Request/status bundle between a self-test sequencer (master) and the
// mechanical-bounce emulator (slave) that drives the raw button lines.
interface btn_bounce_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
);
  logic            req_valid;
  logic            req_ready;
  logic [CH_W-1:0] req_ch;
  logic            req_level;
  logic [N_CH-1:0] btn_out;
  logic            busy;
  logic            done;

  modport master (
    output req_valid, req_ch, req_level,
    input  req_ready, btn_out, busy, done
  );

  modport slave (
    input  req_valid, req_ch, req_level,
    output req_ready, btn_out, busy, done
  );
endinterface

// File: rtl/btn_bounce_gen.sv
// Mechanical-bounce emulator: moves one button line to a new level through a
// burst of alternating segments, holds it for a settle window, then pulses done.
module btn_bounce_gen #(
  parameter int          N_CH          = 4,
  parameter int          CH_W          = 2,
  parameter int          RANDOM        = 1,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          FIXED_BOUNCES = 2,
  parameter int          FIXED_SEG     = 3,
  parameter int          SETTLE_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst,
  btn_bounce_if.slave    bif
);

  localparam int                SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, DONE} state_t;

  state_t          state, state_n;
  logic [15:0]     lfsr;
  logic [N_CH-1:0] btn_q;
  logic [CH_W-1:0] ch_q;
  logic            level_q;
  logic [3:0]      seg_len;
  logic [2:0]      seg_cnt;
  logic [4:0]      idx;
  logic [4:0]      last_idx;
  logic [SET_W-1:0] settle_cnt;
  logic [3:0]      k_pick;
  logic [3:0]      seg_pick;
  logic            accept;
  logic            ch_ok;
  logic            seg_end;
  logic            last_seg;

  // Level of the segment that follows segment i: even segments carry the
  // target level, odd ones its complement.
  function automatic logic next_seg_level(input logic lvl, input logic [4:0] i);
    return lvl ^ ~i[0];
  endfunction

  assign k_pick   = (RANDOM != 0) ? lfsr[3:0] : 4'(FIXED_BOUNCES);
  assign seg_pick = (RANDOM != 0) ? ({1'b0, lfsr[6:4]} + 4'd1) : 4'(FIXED_SEG);
  assign ch_ok    = int'(bif.req_ch) < N_CH;
  assign accept   = bif.req_valid && (state == IDLE);
  assign seg_end  = (seg_cnt == 3'd0);
  assign last_seg = (idx == last_idx);
  assign bif.btn_out = btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    bif.req_ready = 1'b0;
    bif.busy      = 1'b1;
    bif.done      = 1'b0;
    case (state)
      IDLE: begin
        bif.req_ready = 1'b1;
        bif.busy      = 1'b0;
        if (accept) begin
          if (!ch_ok)               state_n = DONE;
          else if (k_pick == 4'd0)  state_n = SETTLE;
          else                      state_n = BOUNCE;
        end
      end
      BOUNCE: if (seg_end && last_seg) state_n = SETTLE;
      SETTLE: if (settle_cnt == '0)    state_n = DONE;
      DONE: begin
        bif.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Segment 0 (or the settle level when there are no bounces) appears in the
  // cycle right after accept, so the line is written on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
    end else if (accept && ch_ok) begin
      btn_q[bif.req_ch] <= bif.req_level;
    end else if ((state == BOUNCE) && seg_end) begin
      btn_q[ch_q] <= next_seg_level(level_q, idx);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ch_q       <= bif.req_ch;
      level_q    <= bif.req_level;
      seg_len    <= seg_pick;
      seg_cnt    <= 3'(seg_pick - 4'd1);
      idx        <= 5'd0;
      last_idx   <= {k_pick, 1'b0} - 5'd1;
      settle_cnt <= SETTLE_LOAD;
    end else if (state == BOUNCE) begin
      if (seg_end) begin
        if (last_seg) begin
          settle_cnt <= SETTLE_LOAD;
        end else begin
          idx     <= idx + 5'd1;
          seg_cnt <= 3'(seg_len - 4'd1);
        end
      end else begin
        seg_cnt <= seg_cnt - 3'd1;
      end
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt - SET_W'(1);
    end
  end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Bench for btn_bounce_gen: three instances (fixed K=2/SEG=3, fixed K=0 with a
// 3-line variant, LFSR-randomised) sharing one driver and one checking task.
module tb_btn_bounce_gen;

  localparam int SETTLE = 32;
  localparam int U0_K   = 2;
  localparam int U0_SEG = 3;

  logic clk;
  logic rst;

  btn_bounce_if #(.N_CH(4), .CH_W(2)) if0 ();
  btn_bounce_if #(.N_CH(3), .CH_W(2)) if1 ();
  btn_bounce_if #(.N_CH(4), .CH_W(2)) if2 ();

  btn_bounce_gen #(.N_CH(4), .CH_W(2), .RANDOM(0), .SEED(16'hACE1),
                   .FIXED_BOUNCES(U0_K), .FIXED_SEG(U0_SEG), .SETTLE_CYCLES(SETTLE))
    u0 (.clk(clk), .rst(rst), .bif(if0.slave));
  btn_bounce_gen #(.N_CH(3), .CH_W(2), .RANDOM(0), .SEED(16'hACE1),
                   .FIXED_BOUNCES(0), .FIXED_SEG(3), .SETTLE_CYCLES(SETTLE))
    u1 (.clk(clk), .rst(rst), .bif(if1.slave));
  btn_bounce_gen #(.N_CH(4), .CH_W(2), .RANDOM(1), .SEED(16'hACE1),
                   .FIXED_BOUNCES(2), .FIXED_SEG(3), .SETTLE_CYCLES(SETTLE))
    u2 (.clk(clk), .rst(rst), .bif(if2.slave));

  int         sel;
  logic       drv_valid;
  logic [1:0] drv_ch;
  logic       drv_level;

  assign if0.req_valid = drv_valid && (sel == 0);
  assign if1.req_valid = drv_valid && (sel == 1);
  assign if2.req_valid = drv_valid && (sel == 2);
  assign if0.req_ch = drv_ch;
  assign if1.req_ch = drv_ch;
  assign if2.req_ch = drv_ch;
  assign if0.req_level = drv_level;
  assign if1.req_level = drv_level;
  assign if2.req_level = drv_level;

  logic [3:0] m_btn;
  logic       m_ready, m_busy, m_done;

  always_comb begin
    m_btn = if0.btn_out; m_ready = if0.req_ready; m_busy = if0.busy; m_done = if0.done;
    if (sel == 1) begin
      m_btn = {1'b0, if1.btn_out}; m_ready = if1.req_ready; m_busy = if1.busy; m_done = if1.done;
    end else if (sel == 2) begin
      m_btn = if2.btn_out; m_ready = if2.req_ready; m_busy = if2.busy; m_done = if2.done;
    end
  end

  // Reference LFSR for the randomised instance: 16-bit Galois, mask B400.
  logic [15:0] mlfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) mlfsr <= 16'hACE1;
    else     mlfsr <= {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [3:0] fin;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [1:0] ch;
    logic       lvl;
    logic [3:0] fin;
    bit         hold;
  } vec_t;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Issue one request on the selected instance and follow it to its done pulse.
  task automatic send(input logic [1:0] ch, input logic lvl, input logic [3:0] fin,
                      input bit hold, input logic [1:0] nch, input logic nlvl);
    int k, seg, lat, t, werr, ierr, tog, nlines;
    bit ch_ok, seen;
    logic [3:0] mask;
    logic eb, lastb;
    exp_t e;
    t = 0;
    while (m_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", {31'd0, m_ready}, 32'd1);
    drv_valid = 1'b1;
    drv_ch    = ch;
    drv_level = lvl;
    if (sel == 2) begin
      k   = int'(mlfsr[3:0]);
      seg = int'(mlfsr[6:4]) + 1;
    end else begin
      k   = (sel == 1) ? 0 : U0_K;
      seg = U0_SEG;
    end
    nlines = (sel == 1) ? 3 : 4;
    ch_ok  = int'(ch) < nlines;
    lat    = ch_ok ? (2 * k * seg + SETTLE + 1) : 1;
    mask   = ch_ok ? (4'b0001 << ch) : 4'b0000;
    e.lat = lat;
    e.fin = fin;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      drv_ch    = nch;
      drv_level = nlvl;
    end else begin
      drv_valid = 1'b0;
    end
    chk("accept", {31'd0, m_busy}, 32'd1);
    werr = 0; ierr = 0; tog = 0; seen = 0; t = 1; lastb = 1'b0;
    while (t <= 300 && !seen) begin
      eb = lvl;
      if (t <= 2 * k * seg && ((t - 1) / seg) % 2 == 1) eb = ~lvl;
      if (ch_ok && m_btn[ch] !== eb) werr++;
      if (m_busy !== 1'b1 || m_ready !== 1'b0) werr++;
      if ((m_btn & ~mask) !== (fin & ~mask)) ierr++;
      if (t > 1 && m_btn[ch] !== lastb) tog++;
      lastb = m_btn[ch];
      if (m_done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: actual=no_done required=done_within_300");
    end
    e = exp_q.pop_front();
    chk("done_latency", t, e.lat);
    chk("final_btn", {28'd0, m_btn}, {28'd0, e.fin});
    chk("wave_errors", werr, 0);
    chk("isolation_errors", ierr, 0);
    chk("toggles", tog, ch_ok ? 2 * k : 0);
    @(negedge clk);
    chk("done_pulse", {30'd0, m_done, m_ready}, 32'd1);
  endtask

  vec_t v0[8];
  vec_t v1[4];
  logic [3:0] shadow, rfin;
  logic [1:0] rch;
  logic       rlvl;
  int         dcnt, bcnt;

  initial begin
    checks = 0; failures = 0;
    sel = 0; drv_valid = 1'b0; drv_ch = 2'd0; drv_level = 1'b0;
    v0[0] = '{2'd1, 1'b1, 4'b0010, 1'b0};
    v0[1] = '{2'd0, 1'b1, 4'b0011, 1'b0};
    v0[2] = '{2'd3, 1'b1, 4'b1011, 1'b0};
    v0[3] = '{2'd0, 1'b1, 4'b1011, 1'b0};
    v0[4] = '{2'd1, 1'b0, 4'b1001, 1'b0};
    v0[5] = '{2'd1, 1'b1, 4'b1011, 1'b0};
    v0[6] = '{2'd2, 1'b1, 4'b1111, 1'b1};
    v0[7] = '{2'd2, 1'b0, 4'b1011, 1'b0};
    v1[0] = '{2'd0, 1'b1, 4'b0001, 1'b0};
    v1[1] = '{2'd3, 1'b1, 4'b0001, 1'b0};
    v1[2] = '{2'd2, 1'b1, 4'b0101, 1'b0};
    v1[3] = '{2'd0, 1'b0, 4'b0100, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_btn", {28'd0, m_btn}, 32'd0);
    chk("reset_ready_busy_done", {29'd0, m_ready, m_busy, m_done}, 32'b100);
    rst = 1'b0;
    @(negedge clk);

    sel = 0;
    for (int i = 0; i < 8; i++) begin
      send(v0[i].ch, v0[i].lvl, v0[i].fin, v0[i].hold,
           v0[(i + 1) % 8].ch, v0[(i + 1) % 8].lvl);
    end

    // Reset five cycles into a transaction: everything clears, no done follows.
    drv_valid = 1'b1; drv_ch = 2'd1; drv_level = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_btn", {28'd0, m_btn}, 32'd0);
    chk("midreset_ready_busy", {30'd0, m_ready, m_busy}, 32'b10);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0; bcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (m_done === 1'b1) dcnt++;
      if (m_btn !== 4'b0000 || m_busy !== 1'b0) bcnt++;
    end
    chk("midreset_no_done", dcnt, 0);
    chk("midreset_idle_after", bcnt, 0);

    sel = 1;
    for (int i = 0; i < 4; i++) begin
      send(v1[i].ch, v1[i].lvl, v1[i].fin, 1'b0, 2'd0, 1'b0);
    end

    sel = 2;
    shadow = 4'b0000;
    for (int n = 0; n < 100; n++) begin
      rch  = 2'($urandom_range(0, 3));
      rlvl = 1'($urandom_range(0, 1));
      rfin = rlvl ? (shadow | (4'b0001 << rch)) : (shadow & ~(4'b0001 << rch));
      send(rch, rlvl, rfin, 1'b0, 2'd0, 1'b0);
      shadow = rfin;
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
